nc_seq_ctrl: RTL and testbench

Command sequencer sitting between the UART receiver/transmitter and the matrix-multiply array inside the neural chip. Parses opcode-framed byte streams, writes operand bytes into the A/B operand arrays, launches the multiply, then streams the result matrix back out over the UART transmit handshake. It owns the `load_arr`, `MULT_DONE` and command-error indications.

---
 rtl/nc_pkg.sv | 34 +++
 rtl/nc_seq_ctrl_if.sv | 45 ++++
 rtl/nc_byte_timer.sv | 30 +++
 rtl/nc_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_nc_seq_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nc_pkg                                                  |
// | Description : Shared constants for the neural-chip command sequencer: |
// |               opcodes, FSM state encoding, result width, helpers.     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package nc_pkg;

  // Command opcodes received over the UART
  localparam logic [7:0] c_OP_LOAD_A = 8'hA1;
  localparam logic [7:0] c_OP_LOAD_B = 8'hB2;
  localparam logic [7:0] c_OP_RUN    = 8'hC3;

  // Width of one result word from the multiply array
  localparam int c_RES_W = 16;

  // Sequencer state encoding
  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_LOAD    = 3'd1;
  localparam logic [2:0] c_ST_START   = 3'd2;
  localparam logic [2:0] c_ST_WAIT    = 3'd3;
  localparam logic [2:0] c_ST_FETCH   = 3'd4;
  localparam logic [2:0] c_ST_SEND_HI = 3'd5;
  localparam logic [2:0] c_ST_SEND_LO = 3'd6;
  localparam logic [2:0] c_ST_DONE    = 3'd7;

  // Index width for an n x n array; never narrower than one bit
  function automatic int addr_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nc_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nc_seq_ctrl_if                                          |
// | Description : UART, operand-array, multiplier and status signals of   |
// |               the command sequencer, bundled with master/slave views. |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface nc_seq_ctrl_if #(
  parameter int N = 2
);
  localparam int AW = nc_pkg::addr_w(N);

  logic                       rx_valid;
  logic [7:0]                 rx_data;
  logic                       rx_error;
  logic                       arr_wr_en;
  logic                       arr_sel;
  logic [AW-1:0]              arr_addr;
  logic [7:0]                 arr_wdata;
  logic                       load_arr;
  logic                       mult_start;
  logic                       mult_done;
  logic [nc_pkg::c_RES_W-1:0] res_data;
  logic                       tx_valid;
  logic [7:0]                 tx_data;
  logic                       tx_ready;
  logic                       MULT_DONE;
  logic                       cmd_err;

  // Sequencer side
  modport master (
    input  rx_valid, rx_data, rx_error, mult_done, res_data, tx_ready,
    output arr_wr_en, arr_sel, arr_addr, arr_wdata, load_arr, mult_start,
           tx_valid, tx_data, MULT_DONE, cmd_err
  );

  // UART / array / multiplier side
  modport slave (
    output rx_valid, rx_data, rx_error, mult_done, res_data, tx_ready,
    input  arr_wr_en, arr_sel, arr_addr, arr_wdata, load_arr, mult_start,
           tx_valid, tx_data, MULT_DONE, cmd_err
  );

endinterface
`default_nettype wire

// File: rtl/nc_byte_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nc_byte_timer                                           |
// | Description : 24-bit inter-byte idle counter; flags expiry on the     |
// |               TIMEOUT-th consecutive enabled cycle without a clear.   |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module nc_byte_timer #(
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  wire logic CLK,
  input  wire logic RESET,
  input  wire logic i_clr,
  input  wire logic i_en,
  output logic      o_expire
);

  logic [23:0] r_count;

  // Count enabled idle cycles; a clear always wins over counting
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (i_en)   r_count <= r_count + 24'd1;
  end

  assign o_expire = i_en && !i_clr && (r_count == TIMEOUT - 24'd1);

endmodule
`default_nettype wire

// File: rtl/nc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nc_seq_ctrl                                             |
// | Description : Opcode-framed command sequencer: loads operand arrays,  |
// |               launches the multiply, streams results over the UART.  |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module nc_seq_ctrl #(
  parameter int          N       = 2,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input wire logic      CLK,
  input wire logic      RESET,
  nc_seq_ctrl_if.master bus
);
  import nc_pkg::*;

  localparam int            AW     = addr_w(N);
  localparam logic [AW-1:0] c_LAST = AW'(N * N - 1);

  logic [2:0]    r_state, w_next_state;
  logic [AW-1:0] r_index, w_index_nxt;
  logic [7:0]    r_buf_lo;
  logic          r_done_d;

  logic          r_wr_en, r_sel, r_load_arr, r_mult_start;
  logic          r_tx_valid, r_mult_done, r_cmd_err;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata, r_tx_data;

  logic w_rx_byte, w_mult_rise, w_tx_hs, w_expire, w_is_op;
  logic w_wr_en, w_load_arr, w_mult_start, w_tx_valid, w_mult_done, w_cmd_err;

  // A received byte only counts when it is not flagged with a framing error
  assign w_rx_byte   = bus.rx_valid && !bus.rx_error;
  assign w_mult_rise = bus.mult_done && !r_done_d;
  assign w_tx_hs     = r_tx_valid && bus.tx_ready;
  assign w_is_op     = (bus.rx_data == c_OP_LOAD_A) || (bus.rx_data == c_OP_LOAD_B) ||
                       (bus.rx_data == c_OP_RUN);

  nc_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_clr    ((r_state != c_ST_LOAD) || w_rx_byte),
    .i_en     (r_state == c_ST_LOAD),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= c_ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and index decode; a framing error aborts from any state
  always_comb begin
    w_next_state = r_state;
    w_index_nxt  = r_index;
    case (r_state)
      c_ST_IDLE: begin
        if (w_rx_byte) begin
          if (bus.rx_data == c_OP_LOAD_A || bus.rx_data == c_OP_LOAD_B) begin
            w_next_state = c_ST_LOAD;
            w_index_nxt  = '0;
          end else if (bus.rx_data == c_OP_RUN) begin
            w_next_state = c_ST_START;
          end
        end
      end
      c_ST_LOAD: begin
        if (w_rx_byte) begin
          if (r_index == c_LAST) begin
            w_next_state = c_ST_IDLE;
            w_index_nxt  = '0;
          end else begin
            w_index_nxt  = r_index + AW'(1);
          end
        end else if (w_expire) begin
          w_next_state = c_ST_IDLE;
        end
      end
      c_ST_START: w_next_state = c_ST_WAIT;
      c_ST_WAIT: begin
        if (w_mult_rise) begin
          w_next_state = c_ST_FETCH;
          w_index_nxt  = '0;
        end
      end
      c_ST_FETCH: w_next_state = c_ST_SEND_HI;
      c_ST_SEND_HI: begin
        if (w_tx_hs) w_next_state = c_ST_SEND_LO;
      end
      c_ST_SEND_LO: begin
        if (w_tx_hs) begin
          if (r_index < c_LAST) begin
            w_next_state = c_ST_FETCH;
            w_index_nxt  = r_index + AW'(1);
          end else begin
            w_next_state = c_ST_DONE;
          end
        end
      end
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
    if (bus.rx_error) w_next_state = c_ST_IDLE;
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    w_wr_en      = (r_state == c_ST_LOAD) && w_rx_byte;
    w_load_arr   = (w_next_state == c_ST_LOAD) || w_wr_en;
    w_mult_start = (w_next_state == c_ST_START);
    w_tx_valid   = (w_next_state == c_ST_SEND_HI) || (w_next_state == c_ST_SEND_LO);
    w_mult_done  = (w_next_state == c_ST_DONE);
    w_cmd_err    = bus.rx_error || w_expire ||
                   (bus.rx_valid && (r_state == c_ST_IDLE) && !w_is_op) ||
                   (bus.rx_valid && (r_state != c_ST_IDLE) && (r_state != c_ST_LOAD));
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_index      <= '0;
      r_buf_lo     <= '0;
      r_done_d     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_sel        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_load_arr   <= 1'b0;
      r_mult_start <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_mult_done  <= 1'b0;
      r_cmd_err    <= 1'b0;
    end else begin
      r_index      <= w_index_nxt;
      r_done_d     <= bus.mult_done;
      r_wr_en      <= w_wr_en;
      r_load_arr   <= w_load_arr;
      r_mult_start <= w_mult_start;
      r_tx_valid   <= w_tx_valid;
      r_mult_done  <= w_mult_done;
      r_cmd_err    <= w_cmd_err;
      if ((r_state == c_ST_IDLE) && (w_next_state == c_ST_LOAD))
        r_sel <= (bus.rx_data == c_OP_LOAD_B);
      if (w_wr_en) begin
        r_addr  <= r_index;
        r_wdata <= bus.rx_data;
      end else if (w_next_state == c_ST_FETCH) begin
        r_addr  <= w_index_nxt;
      end
      // High byte goes straight to the transmitter, low byte waits its turn
      if (r_state == c_ST_FETCH) begin
        r_tx_data <= bus.res_data[c_RES_W-1:8];
        r_buf_lo  <= bus.res_data[7:0];
      end else if ((r_state == c_ST_SEND_HI) && (w_next_state == c_ST_SEND_LO)) begin
        r_tx_data <= r_buf_lo;
      end
    end
  end

  assign bus.arr_wr_en  = r_wr_en;
  assign bus.arr_sel    = r_sel;
  assign bus.arr_addr   = r_addr;
  assign bus.arr_wdata  = r_wdata;
  assign bus.load_arr   = r_load_arr;
  assign bus.mult_start = r_mult_start;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.MULT_DONE  = r_mult_done;
  assign bus.cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_nc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_nc_seq_ctrl                                          |
// | Description : Directed self-checking bench for nc_seq_ctrl (N=2).     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_nc_seq_ctrl;

  localparam int N = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   rand_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  nc_seq_ctrl_if #(.N(N)) bus ();

  nc_seq_ctrl #(.N(N), .TIMEOUT(24'd100)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Random back-pressure on the transmit side when enabled
  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.tx_ready = ($urandom_range(0, 1) == 1);
  end

  // Multiply array model: row-major product of the captured operands
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [4];
  always_comb begin
    int r;
    int c;
    logic [15:0] acc;
    r = int'(bus.arr_addr) / N;
    c = int'(bus.arr_addr) % N;
    acc = '0;
    for (int k = 0; k < N; k++) acc = acc + 16'(mem_a[r*N+k]) * 16'(mem_b[k*N+c]);
    bus.res_data = acc;
  end

  // Event logs gathered on the falling edge
  int wr_cnt = 0, start_cnt = 0, mdone_cnt = 0, err_cnt = 0, tx_cnt = 0;
  int stall_viol = 0, load_viol = 0;
  logic [7:0] wr_data_log [64];
  logic [1:0] wr_addr_log [64];
  logic       wr_sel_log  [64];
  logic [7:0] tx_log      [64];
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] exp_bytes [8] = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};

  always @(negedge clk) begin
    if (bus.arr_wr_en === 1'b1) begin
      if (wr_cnt < 64) begin
        wr_data_log[wr_cnt] = bus.arr_wdata;
        wr_addr_log[wr_cnt] = bus.arr_addr;
        wr_sel_log[wr_cnt]  = bus.arr_sel;
      end
      if (bus.arr_sel) mem_b[bus.arr_addr] = bus.arr_wdata;
      else             mem_a[bus.arr_addr] = bus.arr_wdata;
      if (bus.load_arr !== 1'b1) load_viol++;
      wr_cnt++;
    end
    if (bus.mult_start === 1'b1) start_cnt++;
    if (bus.MULT_DONE === 1'b1)  mdone_cnt++;
    if (bus.cmd_err === 1'b1)    err_cnt++;
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      if (tx_cnt < 64) tx_log[tx_cnt] = bus.tx_data;
      tx_cnt++;
    end
    if (prev_stall && (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data)) stall_viol++;
    prev_stall = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1) && rst_n;
    prev_data  = bus.tx_data;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    cyc();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic pulse_done();
    bus.mult_done = 1'b1;
    cyc();
    bus.mult_done = 1'b0;
  endtask

  task automatic wait_mdone(input int m0, input int budget);
    int t = 0;
    while (mdone_cnt == m0 && t < budget) begin cyc(); t++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    n_checks++;
    if ({bus.arr_wr_en, bus.arr_sel, bus.load_arr, bus.mult_start, bus.tx_valid,
         bus.MULT_DONE, bus.cmd_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.arr_wr_en, bus.arr_sel,
               bus.load_arr, bus.mult_start, bus.tx_valid, bus.MULT_DONE, bus.cmd_err});
    end
    n_checks++;
    if ({bus.arr_addr, bus.arr_wdata, bus.tx_data} !== 18'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 0", {bus.arr_addr, bus.arr_wdata, bus.tx_data});
    end
    rst_n = 1'b1;
    cyc(2);
    n_checks++;
    if (bus.tx_valid !== 1'b0 || bus.load_arr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: tx_valid=%b load_arr=%b want 0 0", bus.tx_valid, bus.load_arr);
    end
  endtask

  task automatic test_load_a();
    int w0 = wr_cnt;
    int lv0 = load_viol;
    send_byte(8'hA1);
    n_checks++;
    if (bus.load_arr !== 1'b1) begin n_fail++; $display("FAIL load_rise: load_arr=%b want 1", bus.load_arr); end
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    n_checks++;
    if (bus.arr_wr_en !== 1'b1 || bus.load_arr !== 1'b1) begin
      n_fail++;
      $display("FAIL load_last: wr_en=%b load_arr=%b want 1 1", bus.arr_wr_en, bus.load_arr);
    end
    cyc();
    n_checks++;
    if (bus.load_arr !== 1'b0 || bus.arr_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fall: load_arr=%b wr_en=%b want 0 0", bus.load_arr, bus.arr_wr_en);
    end
    n_checks++;
    if (wr_cnt - w0 != 4) begin n_fail++; $display("FAIL load_a_count: got %0d want 4", wr_cnt - w0); end
    for (int i = 0; i < 4; i++) begin
      logic [10:0] got, exp;
      got = {wr_sel_log[w0+i], wr_addr_log[w0+i], wr_data_log[w0+i]};
      exp = {1'b0, 2'(i), 8'(i + 1)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL load_a_wr%0d: got %h want %h", i, got, exp); end
    end
    n_checks++;
    if (load_viol != lv0) begin n_fail++; $display("FAIL load_arr_cover: %0d writes outside load_arr want 0", load_viol - lv0); end
  endtask

  task automatic test_load_b_run();
    int w0 = wr_cnt;
    int s0, m0, t0;
    send_byte(8'hB2);
    for (int i = 5; i <= 8; i++) send_byte(8'(i));
    cyc();
    for (int i = 0; i < 4; i++) begin
      logic [10:0] got, exp;
      got = {wr_sel_log[w0+i], wr_addr_log[w0+i], wr_data_log[w0+i]};
      exp = {1'b1, 2'(i), 8'(i + 5)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL load_b_wr%0d: got %h want %h", i, got, exp); end
    end
    s0 = start_cnt; m0 = mdone_cnt; t0 = tx_cnt;
    send_byte(8'hC3);
    n_checks++;
    if (bus.mult_start !== 1'b1) begin n_fail++; $display("FAIL start_rise: mult_start=%b want 1", bus.mult_start); end
    cyc();
    n_checks++;
    if (bus.mult_start !== 1'b0) begin n_fail++; $display("FAIL start_fall: mult_start=%b want 0", bus.mult_start); end
    cyc(3);
    pulse_done();
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_gap: tx_valid=%b want 0", bus.tx_valid); end
    cyc();
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL first_tx: tx_valid=%b tx_data=%h want 1 00", bus.tx_valid, bus.tx_data);
    end
    wait_mdone(m0, 100);
    cyc(3);
    n_checks++;
    if (mdone_cnt - m0 != 1 || start_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL run_pulses: MULT_DONE=%0d mult_start=%0d want 1 1", mdone_cnt - m0, start_cnt - s0);
    end
    n_checks++;
    if (tx_cnt - t0 != 8) begin n_fail++; $display("FAIL run_bytes: got %0d want 8", tx_cnt - t0); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tx_log[t0+i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL run_byte%0d: got %h want %h", i, tx_log[t0+i], exp_bytes[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int m0 = mdone_cnt;
    int t0 = tx_cnt;
    int v0 = stall_viol;
    rand_ready = 1'b1;
    send_byte(8'hC3);
    cyc(2);
    pulse_done();
    wait_mdone(m0, 400);
    rand_ready = 1'b0;
    cyc();
    bus.tx_ready = 1'b1;
    n_checks++;
    if (mdone_cnt - m0 != 1 || tx_cnt - t0 != 8) begin
      n_fail++;
      $display("FAIL stall_run: MULT_DONE=%0d bytes=%0d want 1 8", mdone_cnt - m0, tx_cnt - t0);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (tx_log[t0+i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, tx_log[t0+i], exp_bytes[i]);
      end
    end
    n_checks++;
    if (stall_viol != v0) begin n_fail++; $display("FAIL stall_stable: %0d changes while stalled want 0", stall_viol - v0); end
  endtask

  task automatic test_bad_opcode();
    int w0 = wr_cnt;
    int s0 = start_cnt;
    int e0 = err_cnt;
    send_byte(8'h55);
    n_checks++;
    if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL bad_op_err: cmd_err=%b want 1", bus.cmd_err); end
    cyc(3);
    n_checks++;
    if (err_cnt - e0 != 1 || wr_cnt != w0 || start_cnt != s0) begin
      n_fail++;
      $display("FAIL bad_op_effect: errs=%0d writes=%0d starts=%0d want 1 0 0", err_cnt - e0, wr_cnt - w0, start_cnt - s0);
    end
  endtask

  task automatic test_rx_error();
    int w0 = wr_cnt;
    int e0 = err_cnt;
    send_byte(8'hA1);
    send_byte(8'h01);
    bus.rx_error = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
    cyc();
    bus.rx_error = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    n_checks++;
    if (bus.cmd_err !== 1'b1 || bus.load_arr !== 1'b0) begin
      n_fail++;
      $display("FAIL rxerr_abort: cmd_err=%b load_arr=%b want 1 0", bus.cmd_err, bus.load_arr);
    end
    cyc(2);
    n_checks++;
    if (wr_cnt - w0 != 1 || err_cnt - e0 != 1) begin
      n_fail++;
      $display("FAIL rxerr_discard: writes=%0d errs=%0d want 1 1", wr_cnt - w0, err_cnt - e0);
    end
    send_byte(8'hA1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    cyc();
    n_checks++;
    if (wr_cnt - w0 != 5 || wr_addr_log[w0+1] !== 2'd0 || wr_data_log[w0+1] !== 8'h01) begin
      n_fail++;
      $display("FAIL rxerr_restart: writes=%0d addr=%0d data=%h want 5 0 01",
               wr_cnt - w0, wr_addr_log[w0+1], wr_data_log[w0+1]);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA1);
    send_byte(8'h01);
    cyc(99);
    n_checks++;
    if (bus.cmd_err !== 1'b0 || bus.load_arr !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: cmd_err=%b load_arr=%b want 0 1", bus.cmd_err, bus.load_arr);
    end
    cyc();
    n_checks++;
    if (bus.cmd_err !== 1'b1 || bus.load_arr !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: cmd_err=%b load_arr=%b want 1 0", bus.cmd_err, bus.load_arr);
    end
    cyc();
    n_checks++;
    if (bus.cmd_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: cmd_err=%b want 0", bus.cmd_err); end
  endtask

  task automatic test_wait_byte();
    int m0 = mdone_cnt;
    int t0 = tx_cnt;
    send_byte(8'hC3);
    cyc(3);
    send_byte(8'h11);
    n_checks++;
    if (bus.cmd_err !== 1'b1) begin n_fail++; $display("FAIL wait_byte_err: cmd_err=%b want 1", bus.cmd_err); end
    cyc(2);
    pulse_done();
    wait_mdone(m0, 100);
    cyc();
    n_checks++;
    if (mdone_cnt - m0 != 1 || tx_cnt - t0 != 8 || tx_log[t0+7] !== 8'h32) begin
      n_fail++;
      $display("FAIL wait_byte_run: MULT_DONE=%0d bytes=%0d last=%h want 1 8 32",
               mdone_cnt - m0, tx_cnt - t0, tx_log[t0+7]);
    end
  endtask

  task automatic test_reset_mid_send();
    int t = 0;
    bus.tx_ready = 1'b0;
    send_byte(8'hC3);
    cyc(2);
    pulse_done();
    while (bus.tx_valid !== 1'b1 && t < 20) begin cyc(); t++; end
    bus.tx_ready = 1'b1;
    cyc();
    bus.tx_ready = 1'b0;
    cyc();
    n_checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h13) begin
      n_fail++;
      $display("FAIL send_lo_hold: tx_valid=%b tx_data=%h want 1 13", bus.tx_valid, bus.tx_data);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.arr_wr_en, bus.arr_sel, bus.load_arr, bus.mult_start, bus.tx_valid,
         bus.MULT_DONE, bus.cmd_err, bus.tx_data, bus.arr_addr, bus.arr_wdata} !== 25'b0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h want 0", {bus.arr_wr_en, bus.arr_sel, bus.load_arr,
               bus.mult_start, bus.tx_valid, bus.MULT_DONE, bus.cmd_err, bus.tx_data,
               bus.arr_addr, bus.arr_wdata});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.tx_ready = 1'b1;
    cyc(2);
    n_checks++;
    if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_tx: tx_valid=%b want 0", bus.tx_valid); end
    send_byte(8'hC3);
    n_checks++;
    if (bus.mult_start !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: mult_start=%b want 1", bus.mult_start); end
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_error  = 1'b0;
    bus.mult_done = 1'b0;
    bus.tx_ready  = 1'b1;
    test_reset();
    test_load_a();
    test_load_b_run();
    test_back_to_back();
    test_bad_opcode();
    test_rx_error();
    test_timeout();
    test_wait_byte();
    test_reset_mid_send();
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
